// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single datamemory load/store port between two masters.
//   Port 0 (CPU memory stage) has fixed priority; port 1 (DMA / debug loader) is
//   guaranteed a slot after STARVE_LIMIT consecutive lost cycles.
// Ports:
//   clk, reset          clock, async active-high reset
//   mN_req/we/addr/wd/funct3   request side of master N (held until mN_gnt)
//   mN_gnt              combinational grant, access happens this cycle
//   mN_rvalid/mN_rdata  registered load return, one cycle after the grant
//   MemRead/MemWrite/a/wd/Funct3  drive to datamemory (all 0 when idle)
//   rd                  load data from datamemory

// Per-port read return: captures rd at the end of a granted load.
module dmem_arbiter_rport #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld,
  input  logic [DATA_W-1:0] rd,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= ld;
      if (ld) rdata <= rd;
    end
  end
endmodule

module dmem_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [DM_ADDRESS-1:0] m0_addr,
  input  logic [DATA_W-1:0]     m0_wd,
  input  logic [2:0]            m0_funct3,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [DM_ADDRESS-1:0] m1_addr,
  input  logic [DATA_W-1:0]     m1_wd,
  input  logic [2:0]            m1_funct3,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);
  localparam int NP = 2;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          starve;

  // Port 1 takes the slot once it has lost STARVE_LIMIT cycles in a row.
  assign starve = (wait_cnt >= CW'(STARVE_LIMIT));
  assign m1_gnt = m1_req & (~m0_req | starve);
  assign m0_gnt = m0_req & ~m1_gnt;

  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    a        = '0;
    wd       = '0;
    Funct3   = '0;
    if (m1_gnt) begin
      MemRead  = ~m1_we;
      MemWrite = m1_we;
      a        = m1_addr;
      wd       = m1_wd;
      Funct3   = m1_funct3;
    end else if (m0_gnt) begin
      MemRead  = ~m0_we;
      MemWrite = m0_we;
      a        = m0_addr;
      wd       = m0_wd;
      Funct3   = m0_funct3;
    end
  end

  // Counts consecutive cycles port 1 waited; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (m1_gnt | ~m1_req) wait_cnt <= '0;
    else if (!starve)          wait_cnt <= wait_cnt + CW'(1);
  end

  logic [NP-1:0]             ld;
  logic [NP-1:0]             rv;
  logic [NP-1:0][DATA_W-1:0] rdq;

  assign ld = {m1_gnt & ~m1_we, m0_gnt & ~m0_we};

  for (genvar i = 0; i < NP; i++) begin : g_rport
    dmem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
      .clk    (clk),
      .reset  (reset),
      .ld     (ld[i]),
      .rd     (rd),
      .rvalid (rv[i]),
      .rdata  (rdq[i])
    );
  end

  assign m0_rvalid = rv[0];
  assign m1_rvalid = rv[1];
  assign m0_rdata  = rdq[0];
  assign m1_rdata  = rdq[1];
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter placed in front of `datamemory`, sharing its single load/store port between the CPU memory stage (port 0) and a secondary master such as DMA or a debug loader (port 1). Port 0 has fixed priority. A wait counter guarantees port 1 a slot after a bounded number of lost cycles. The block grants one access per cycle, drives the `datamemory` control and data inputs combinationally from the winner, and returns load data registered one cycle later with a per-port valid pulse.

## Interface
- `DM_ADDRESS`, 9, byte-address width, matches `datamemory`
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive lost cycles after which port 1 wins; legal range ≥ 1

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mN_req`  in  1  access request, N ∈ {0,1}
- `mN_we`  in  1  1 = store, 0 = load
- `mN_addr`  in  DM_ADDRESS  byte address
- `mN_wd`  in  DATA_W  store data
- `mN_funct3`  in  3  RISC-V width/sign code, passed through unchanged
- `mN_gnt`  out  1  combinational grant; the access is performed this cycle
- `mN_rvalid`  out  1  load data valid; one-cycle pulse
- `mN_rdata`  out  DATA_W  registered load data
- `MemRead`, `MemWrite`  out  1  to `datamemory`
- `a`  out  DM_ADDRESS  to `datamemory`
- `wd`  out  DATA_W  to `datamemory`
- `Funct3`  out  3  to `datamemory`
- `rd`  in  DATA_W  from `datamemory`

## Operation
- Requester rule: once `mN_req` is asserted, the port holds `req`, `we`, `addr`, `wd` and `funct3` stable until it sees `mN_gnt`=1. The arbiter does not check this.
- Starvation signal: `force = (wait_cnt >= STARVE_LIMIT)`. `wait_cnt` is `$clog2(STARVE_LIMIT+1)` bits wide and saturates at `STARVE_LIMIT`.
- Grant logic, combinational:
  - `m1_gnt = m1_req & (~m0_req | force)`
  - `m0_gnt = m0_req & ~m1_gnt`
  - `mN_gnt` is never asserted without `mN_req`.
  - At most one grant is asserted per cycle.
- Memory drive:
  - With a grant: `MemRead = ~we`, `MemWrite = we`, and `a`, `wd`, `Funct3` come from the winning port.
  - With no grant: all five outputs are 0.
- `wait_cnt` update on the rising edge:
  - Set to 0 if `m1_gnt` = 1 or `m1_req` = 0.
  - Otherwise incremented by 1 when `m1_req` = 1 and port 1 lost.
- Read return on the rising edge ending a granted load:
  - `mN_rdata <= rd` and `mN_rvalid <= 1`.
  - `mN_rvalid` clears on the next edge unless another load is granted to the same port.
  - `mN_rdata` holds its value between loads.
- Stores produce no `rvalid`. The store is complete when `gnt` is seen (`datamemory` writes on the falling edge of the same cycle).
- Back-to-back grants to the same port are allowed every cycle. `rvalid` can then stay high for consecutive cycles, carrying new data each cycle.
- A same-cycle request on both ports with `force` = 0 is resolved as port 0 granted, port 1 held.
- Reset, asynchronous, may arrive mid-operation:
  - `wait_cnt` = 0, `m0_rvalid` = `m1_rvalid` = 0, `m0_rdata` = `m1_rdata` = 0.
  - A load granted in the cycle reset asserts never returns data.
  - Grant and memory outputs stay combinational during reset; requesters must deassert `req` while in reset.

## Timing
- Grant latency: 0 cycles. `gnt` is valid in the same cycle as `req` when the port wins.
- Load latency: `rvalid` and `rdata` appear 1 cycle after the grant cycle.
- Worst-case port 1 wait under a continuous port 0 stream: `STARVE_LIMIT` cycles. The grant comes in cycle `STARVE_LIMIT` counted from 0.
- Sustained steady state with both ports requesting: port 0 wins `STARVE_LIMIT` cycles, then port 1 wins 1, repeating. With the default this is 4:1.
- Port 0 worst-case wait: 1 cycle per forced port 1 grant.
- Critical path: `req` → grant → `a` → `datamemory` → `rd`, then the `rdata` register. No registered stage exists on the request side.

## Test plan
- Reset: assert `reset` mid-stream with a load granted. Required: `rvalid` = 0, `rdata` = 0, `wait_cnt` = 0 immediately; no `rvalid` pulse after release.
- Single port 0 word access: SW to address 0x010 with `wd` = 0xDEADBEEF, `funct3` = 010, then LW from 0x010. Required: `m0_gnt` high in both cycles, and `m0_rvalid` one cycle after the LW with `m0_rdata` = 0xDEADBEEF.
- Starvation bound: `m0_req` held continuously and `m1_req` asserted from cycle 0 with default `STARVE_LIMIT` = 4. Required: `m0_gnt` in cycles 0–3, `m1_gnt` in cycle 4, `m0_gnt` in cycles 5–8, `m1_gnt` in cycle 9.
- Port 1 sub-word load while port 0 is idle: LB at 0x003 with the memory word = 0x80112233. Required: `m1_gnt` = 1 in the same cycle, then `m1_rdata` = 0xFFFFFF80 with a 1-cycle `m1_rvalid` pulse.
- Store/load interleave across ports, same word:
  - Cycle 0: port 0 SB writes 0xAA to 0x021.
  - Cycle 1: port 1 LW from 0x020, with the prior word 0x00000000.
  - Required: `m1_rdata` = 0x0000AA00, and no `rvalid` is generated for the store.
- Idle bus: both `req` = 0 for 3 cycles. Required: `MemRead` = `MemWrite` = 0, `a` = 0, `wd` = 0, `Funct3` = 0, and both `rvalid` = 0.
